// File: rtl/jts16_line_fetch.sv
// Per-scanline tilemap fetch scheduler: walks every (column, layer) slot on line start,
// fetches one ROM word per slot and writes it into a double-buffered line store.
module jts16_line_fetch #(
    parameter int LAYERS = 2,
    parameter int COLS   = 42,
    parameter int DW     = 32,
    localparam int LW    = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hinit,
    input  logic [8:0]       vrender,
    input  logic             LVBL,
    output logic             rom_cs,
    output logic [LW+14:0]   rom_addr,
    input  logic             rom_ok,
    input  logic [DW-1:0]    rom_data,
    output logic             buf_we,
    output logic [LW+6:0]    buf_addr,
    output logic [DW-1:0]    buf_din,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StWrite, StDone} state_t;

    state_t          state_q, state_d;
    logic [8:0]      line_q, line_d;
    logic [5:0]      col_q, col_d;
    logic [LW-1:0]   layer_q, layer_d;
    logic [DW-1:0]   data_q, data_d;
    logic            got_q, got_d;     // data already captured during the ISSUE cycle
    logic            trig;
    logic            active;

    assign trig     = hinit && LVBL;
    assign active   = (state_q == StIssue) || (state_q == StWait) || (state_q == StWrite);
    assign rom_addr = {layer_q, line_q, col_q};
    assign buf_addr = {line_q[0], layer_q, col_q};
    assign buf_din  = data_q;

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        col_d   = col_q;
        layer_d = layer_q;
        data_d  = data_q;
        got_d   = got_q;
        rom_cs  = 1'b0;
        buf_we  = 1'b0;
        done    = 1'b0;
        overrun = 1'b0;
        busy    = active;

        unique case (state_q)
            StIdle: ;
            StIssue: begin
                rom_cs  = 1'b1;
                state_d = StWait;
                if (rom_ok) begin
                    data_d = rom_data;
                    got_d  = 1'b1;
                end
            end
            StWait: begin
                rom_cs = !got_q;
                if (got_q) begin
                    state_d = StWrite;
                end else if (rom_ok) begin
                    data_d  = rom_data;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                buf_we = 1'b1;
                got_d  = 1'b0;
                state_d = StIssue;
                // Layer advances first so a truncated line leaves all layers equally short
                if (layer_q == LW'(LAYERS - 1)) begin
                    if (col_q == 6'(COLS - 1)) begin
                        state_d = StDone;
                    end else begin
                        layer_d = '0;
                        col_d   = col_q + 6'd1;
                    end
                end else begin
                    layer_d = layer_q + LW'(1);
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A new line start overrides whatever slot is in flight
        if (trig) begin
            if (active) begin
                overrun = 1'b1;
                rom_cs  = 1'b0;
                buf_we  = 1'b0;
            end
            state_d = StIssue;
            line_d  = vrender;
            col_d   = '0;
            layer_d = '0;
            got_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            line_q  <= '0;
            col_q   <= '0;
            layer_q <= '0;
            data_q  <= '0;
            got_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            col_q   <= col_d;
            layer_q <= layer_d;
            data_q  <= data_d;
            got_q   <= got_d;
        end
    end

endmodule
